// File: rtl/ahb_cache_arbiter_pkg.sv
// Shared AHB-Lite encodings and arbiter FSM state type for the I/D cache line-fill arbiter.
package ahb_cache_arbiter_pkg;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_e;

    localparam logic [2:0] HsizeWord   = 3'b010;
    localparam logic [2:0] HburstIncr4 = 3'b011;
    localparam logic [2:0] HburstIncr8 = 3'b101;
    localparam logic [3:0] HprotIFetch = 4'b0010;
    localparam logic [3:0] HprotDData  = 4'b0011;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StBurst,
        StLast,
        StErr
    } state_e;

    function automatic logic [2:0] burst_enc(input int unsigned words);
        return (words == 4) ? HburstIncr4 : HburstIncr8;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant choice with the last-grant register (0 = I, 1 = D).
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic load_i,
    output logic pick_d_o,
    output logic gnt_d_o
);

    logic last_d_q;

    // On a tie the side that did not win last time takes the grant.
    always_comb begin
        pick_d_o = d_req_i & (~i_req_i | ~last_d_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else if (load_i && (i_req_i || d_req_i)) begin
            last_d_q <= pick_d_o;
        end
    end

    assign gnt_d_o = last_d_q;

endmodule

// File: rtl/ahb_cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/write-backs onto one AHB-Lite master port
// as fixed-length incrementing line bursts.
module ahb_cache_arbiter
    import ahb_cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_rvalid,
    output logic [2:0]        i_beat,
    output logic              i_done,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_rvalid,
    output logic [2:0]        d_beat,
    output logic              d_done,
    output logic              d_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam logic [2:0] LastBeat = 3'(LINE_WORDS - 1);

    state_e            state_q, state_d;
    logic [2:0]        abeat_q, abeat_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              arb_load, pick_d, gnt_d;
    logic              beat_acc, xfer_done, xfer_err;
    logic              granted, dphase, wr_grant;
    logic [2:0]        dbeat;

    rr_arbiter2 u_rr_arbiter2 (
        .clk      (clk),
        .reset    (reset),
        .i_req_i  (i_req),
        .d_req_i  (d_req),
        .load_i   (arb_load),
        .pick_d_o (pick_d),
        .gnt_d_o  (gnt_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            abeat_q <= 3'd0;
            haddr_q <= '0;
        end else begin
            state_q <= state_d;
            abeat_q <= abeat_d;
            haddr_q <= haddr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        abeat_d   = abeat_q;
        haddr_d   = haddr_q;
        arb_load  = 1'b0;
        beat_acc  = 1'b0;
        xfer_done = 1'b0;
        xfer_err  = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    arb_load = 1'b1;
                    state_d  = StAddr;
                    abeat_d  = 3'd0;
                    haddr_d  = pick_d ? d_addr : i_addr;
                end
            end
            StAddr: begin
                if (HREADY) begin
                    state_d = StBurst;
                    abeat_d = abeat_q + 3'd1;
                    haddr_d = haddr_q + ADDR_W'(4);
                end
            end
            StBurst: begin
                if (HRESP && !HREADY) begin
                    state_d = StErr;
                end else if (HREADY) begin
                    beat_acc = 1'b1;
                    if (abeat_q == LastBeat) begin
                        state_d = StLast;
                    end else begin
                        abeat_d = abeat_q + 3'd1;
                        haddr_d = haddr_q + ADDR_W'(4);
                    end
                end
            end
            StLast: begin
                if (HRESP && !HREADY) begin
                    state_d = StErr;
                end else if (HREADY) begin
                    beat_acc  = 1'b1;
                    xfer_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            StErr: begin
                // Second cycle of the ERROR response ends the line; remaining beats are dropped.
                if (HREADY) begin
                    xfer_done = 1'b1;
                    xfer_err  = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        granted  = (state_q != StIdle);
        dphase   = (state_q == StBurst) || (state_q == StLast);
        wr_grant = gnt_d & d_write;
        // In BURST the data phase trails the address beat by one; in LAST it is the final beat.
        dbeat    = (state_q == StBurst) ? (abeat_q - 3'd1) : abeat_q;
    end

    always_comb begin
        HTRANS = HtransIdle;
        if (state_q == StAddr) begin
            HTRANS = HtransNonseq;
        end else if (state_q == StBurst) begin
            HTRANS = HtransSeq;
        end
    end

    assign HADDR     = haddr_q;
    assign HWRITE    = ((state_q == StAddr) || (state_q == StBurst)) && wr_grant;
    assign HSIZE     = HsizeWord;
    assign HBURST    = granted ? burst_enc(LINE_WORDS) : 3'b000;
    assign HPROT     = granted ? (gnt_d ? HprotDData : HprotIFetch) : 4'b0000;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = (dphase && wr_grant) ? d_wdata : 32'd0;

    assign i_rvalid = beat_acc & ~gnt_d;
    assign d_rvalid = beat_acc & gnt_d & ~d_write;
    assign i_rdata  = i_rvalid ? HRDATA : 32'd0;
    assign d_rdata  = d_rvalid ? HRDATA : 32'd0;
    assign i_beat   = (dphase && !gnt_d) ? dbeat : 3'd0;
    assign d_beat   = (dphase && gnt_d) ? dbeat : 3'd0;
    assign i_done   = xfer_done & ~gnt_d;
    assign d_done   = xfer_done & gnt_d;
    assign i_err    = xfer_err & ~gnt_d;
    assign d_err    = xfer_err & gnt_d;

endmodule

// File: tb/tb_ahb_cache_arbiter.sv
// Directed bench: table of line transfers against a small AHB slave model, plus tie and reset cases.
module tb_ahb_cache_arbiter;

    localparam int LW   = 8;
    localparam int NONE = 15;

    logic        clk, reset;
    logic        i_req, d_req, d_write;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_rvalid, i_done, i_err, d_rvalid, d_done, d_err;
    logic [2:0]  i_beat, d_beat;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester supplies the write word for the beat the arbiter shows.
    assign d_wdata = 32'h0000_00A0 + {29'd0, d_beat};

    ahb_cache_arbiter #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_beat    (i_beat),
        .i_done    (i_done),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_beat    (d_beat),
        .d_done    (d_done),
        .d_err     (d_err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] base;
        int          stall_beat;
        int          stall_n;
        int          err_beat;
        int          exp_done;
        int          exp_beats;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_htrans"}, {30'd0, HTRANS}, 32'd0);
        chk({tag, "_haddr"}, HADDR, 32'd0);
        chk({tag, "_hwrite"}, {31'd0, HWRITE}, 32'd0);
        chk({tag, "_hwdata"}, HWDATA, 32'd0);
        chk({tag, "_hburst"}, {29'd0, HBURST}, 32'd0);
        chk({tag, "_hprot"}, {28'd0, HPROT}, 32'd0);
        chk({tag, "_strobes"}, {26'd0, i_rvalid, i_done, i_err, d_rvalid, d_done, d_err}, 32'd0);
        chk({tag, "_rdata"}, i_rdata | d_rdata, 32'd0);
        chk({tag, "_beats"}, {26'd0, i_beat, d_beat}, 32'd0);
    endtask

    // Runs one granted line from cycle 0 (request visible) to its done pulse, acting as the slave.
    task automatic serve(input logic is_d, input logic wr, input logic [31:0] base,
                         input int stall_beat, input int stall_n, input int err_beat,
                         input int exp_done, input int exp_beats, input logic keep);
        int cyc = 0, nxt = 0, pk = 0, stall_left = stall_n, beats = 0, done_cyc = -1;
        bit pend = 0, err_ph = 0, fin = 0;
        logic acc, edone, exp_dn, addr_act;
        logic x_rv, x_dn, x_er, o_rv, o_dn, o_er;
        logic [31:0] x_rd, exp_rd;
        logic [2:0] x_bt;
        while (!fin && cyc < 40) begin
            if (pend) begin
                HRDATA = 32'hC0DE_0000 ^ (base + 32'(4 * pk));
                if (pk == err_beat) begin
                    HREADY = err_ph;
                    HRESP  = 1'b1;
                end else if (pk == stall_beat && stall_left > 0) begin
                    HREADY = 1'b0;
                    HRESP  = 1'b0;
                    stall_left--;
                end else begin
                    HREADY = 1'b1;
                    HRESP  = 1'b0;
                end
            end else begin
                HREADY = 1'b1;
                HRESP  = 1'b0;
                HRDATA = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            x_rv = is_d ? d_rvalid : i_rvalid;
            x_dn = is_d ? d_done : i_done;
            x_er = is_d ? d_err : i_err;
            x_rd = is_d ? d_rdata : i_rdata;
            x_bt = is_d ? d_beat : i_beat;
            o_rv = is_d ? i_rvalid : d_rvalid;
            o_dn = is_d ? i_done : d_done;
            o_er = is_d ? i_err : d_err;
            acc    = pend && HREADY && !HRESP;
            edone  = pend && (pk == err_beat) && err_ph;
            exp_dn = (acc && pk == LW - 1) || edone;
            chk("rvalid", {31'd0, x_rv}, {31'd0, acc && !wr});
            chk("done", {31'd0, x_dn}, {31'd0, exp_dn});
            chk("err", {31'd0, x_er}, {31'd0, edone});
            chk("other_side_strobes", {29'd0, o_rv, o_dn, o_er}, 32'd0);
            if (acc && !wr) begin
                exp_rd = 32'hC0DE_0000 ^ (base + 32'(4 * pk));
                chk("rdata", x_rd, exp_rd);
                chk("beat", {29'd0, x_bt}, 32'(pk));
            end
            if (pend && wr && pk != err_beat) begin
                chk("hwdata", HWDATA, 32'hA0 + 32'(pk));
            end
            addr_act = (cyc >= 1) && (nxt < LW) && !err_ph;
            if (addr_act) begin
                chk("htrans", {30'd0, HTRANS}, (nxt == 0) ? 32'd2 : 32'd3);
                chk("haddr", HADDR, base + 32'(4 * nxt));
                chk("hwrite", {31'd0, HWRITE}, {31'd0, wr});
                chk("hprot", {28'd0, HPROT}, is_d ? 32'h3 : 32'h2);
                chk("hburst", {29'd0, HBURST}, 32'h5);
                chk("hsize", {29'd0, HSIZE}, 32'h2);
                chk("hmastlock", {31'd0, HMASTLOCK}, 32'd0);
            end else begin
                chk("htrans_idle", {30'd0, HTRANS}, 32'd0);
                if (cyc == 0) chk("hwrite_idle", {31'd0, HWRITE}, 32'd0);
            end
            if (acc) beats++;
            if (x_dn) done_cyc = cyc;
            if (x_dn || exp_dn) fin = 1;
            if (pend && !HREADY) begin
                if (pk == err_beat) err_ph = 1;
            end else begin
                pend = 0;
                if (addr_act && HREADY) begin
                    pend = 1;
                    pk   = nxt;
                    nxt++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (fin && !keep) begin
                if (is_d) d_req = 1'b0;
                else i_req = 1'b0;
            end
        end
        chk("done_cycle", 32'(done_cyc), 32'(exp_done));
        chk("beats_delivered", 32'(beats), 32'(exp_beats));
    endtask

    initial begin
        //          is_d  wr    base          stall  n  err   done beats
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, NONE, 0, NONE, 9,  8};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_2000, NONE, 0, NONE, 9,  8};
        tbl[2] = '{1'b0, 1'b0, 32'h0000_0500, 3,    3, NONE, 12, 8};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0600, NONE, 0, 2,    5,  2};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_0700, NONE, 0, NONE, 9,  8};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0800, 0,    2, NONE, 11, 8};
        tbl[6] = '{1'b0, 1'b0, 32'h0000_0040, NONE, 0, 0,    3,  0};
        tbl[7] = '{1'b1, 1'b0, 32'h0000_0900, NONE, 0, 7,    10, 7};

        reset   = 1'b1;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_write = 1'b0;
        i_addr  = 32'd0;
        d_addr  = 32'd0;
        HREADY  = 1'b1;
        HRESP   = 1'b0;
        HRDATA  = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Tie right after reset goes to D; D re-requesting at once then loses the next tie to I.
        i_addr = 32'h0000_0300;
        d_addr = 32'h0000_0400;
        i_req  = 1'b1;
        d_req  = 1'b1;
        serve(1'b1, 1'b0, 32'h0000_0400, NONE, 0, NONE, 9, 8, 1'b1);
        serve(1'b0, 1'b0, 32'h0000_0300, NONE, 0, NONE, 9, 8, 1'b0);
        serve(1'b1, 1'b0, 32'h0000_0400, NONE, 0, NONE, 9, 8, 1'b0);

        for (int i = 0; i < 8; i++) begin
            d_write = tbl[i].is_d & tbl[i].wr;
            if (tbl[i].is_d) begin
                d_addr = tbl[i].base;
                d_req  = 1'b1;
            end else begin
                i_addr = tbl[i].base;
                i_req  = 1'b1;
            end
            serve(tbl[i].is_d, tbl[i].wr, tbl[i].base, tbl[i].stall_beat, tbl[i].stall_n,
                  tbl[i].err_beat, tbl[i].exp_done, tbl[i].exp_beats, 1'b0);
        end

        // Reset while beat 4 of a write-back is in its data phase.
        d_addr  = 32'h0000_2000;
        d_write = 1'b1;
        d_req   = 1'b1;
        HREADY  = 1'b1;
        HRESP   = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("pre_reset_hwdata", HWDATA, 32'h0000_00A4);
        chk("pre_reset_htrans", {30'd0, HTRANS}, 32'd3);
        reset = 1'b1;
        #1;
        check_reset_vals("mid");
        d_req   = 1'b0;
        d_write = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("no_done_in_reset", {30'd0, i_done, d_done}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("no_done_after_reset", {30'd0, i_done, d_done}, 32'd0);
        chk("idle_after_reset", {30'd0, HTRANS}, 32'd0);
        @(posedge clk);
        #1;
        d_addr  = 32'h0000_2000;
        d_write = 1'b1;
        d_req   = 1'b1;
        serve(1'b1, 1'b1, 32'h0000_2000, NONE, 0, NONE, 9, 8, 1'b0);
        d_write = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
